// File: rtl/simd_alu_cmp_mask_reducer.sv
// Two-stage reducer that turns the SIMD comparer result vector into a lane mask with any/all/count/mode_err.
// Optional macro SIMD_CMP_POPCOUNT_EN enables the registered match count; otherwise count reads 0.
module simd_alu_cmp_mask_reducer #(
    parameter int  SIMD_DATA_WIDTH            = 256,
    parameter int  SIMD_ADDER_DATA_MODE_WIDTH = 2,
    localparam int LANES_MAX                  = SIMD_DATA_WIDTH / 8,
    localparam int CNT_W                      = $clog2(LANES_MAX + 1),
    localparam int MW                         = SIMD_ADDER_DATA_MODE_WIDTH
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic [SIMD_DATA_WIDTH-1:0] i_result,
    input  logic [MW-1:0]              i_data_mode,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [LANES_MAX-1:0]       o_mask,
    output logic                       o_any,
    output logic                       o_all,
    output logic [CNT_W-1:0]           o_count,
    output logic                       o_mode_err
);

    logic                          r_s1_v, r_s2_v;
    logic [LANES_MAX-1:0]          r_s1_lsb;
    logic [MW-1:0]                 r_s1_mode;
    logic [LANES_MAX-1:0]          r_mask;
    logic                          r_any, r_all, r_mode_err;
    logic                          w_s2_adv, w_accept, w_xfer;
    logic [LANES_MAX-1:0]          w_lsb;
    logic [3:0][LANES_MAX-1:0]     w_lane, w_act;
    logic [LANES_MAX-1:0]          w_mask;
    logic                          w_any, w_all, w_mode_err;
    logic                          w_unused_bits;

    assign w_s2_adv   = !r_s2_v | i_out_ready;
    assign w_xfer     = r_s1_v & w_s2_adv;
    assign o_in_ready = !i_rst & (!r_s1_v | w_s2_adv);
    assign w_accept   = i_in_valid & o_in_ready;

    // Every lane LSB in any mode sits on a byte boundary, so only byte LSBs are stored in S1.
    for (genvar gi = 0; gi < LANES_MAX; gi++) begin : g_lsb
        assign w_lsb[gi] = i_result[gi*8];
    end
    assign w_unused_bits = ^i_result;

    // In mode m, lane i is byte lane (i << m); lanes beyond the mode's count read 0.
    for (genvar gm = 0; gm < 4; gm++) begin : g_mode
        for (genvar gi = 0; gi < LANES_MAX; gi++) begin : g_lane
            if (gi < (LANES_MAX >> gm)) begin : g_on
                assign w_lane[gm][gi] = r_s1_lsb[gi << gm];
                assign w_act[gm][gi]  = 1'b1;
            end else begin : g_off
                assign w_lane[gm][gi] = 1'b0;
                assign w_act[gm][gi]  = 1'b0;
            end
        end
    end

    if (MW > 2) begin : g_merr
        assign w_mode_err = |r_s1_mode[MW-1:2];
    end else begin : g_nomerr
        assign w_mode_err = 1'b0;
    end

    always_comb begin
        w_mask = '0;
        w_all  = 1'b0;
        if (!w_mode_err) begin
            w_mask = w_lane[r_s1_mode[1:0]];
            w_all  = &(w_mask | ~w_act[r_s1_mode[1:0]]);
        end
    end
    assign w_any = |w_mask;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_v     <= 1'b0;
            r_s2_v     <= 1'b0;
            r_mask     <= '0;
            r_any      <= 1'b0;
            r_all      <= 1'b0;
            r_mode_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_lsb  <= w_lsb;
                r_s1_mode <= i_data_mode;
                r_s1_v    <= 1'b1;
            end else if (w_xfer) begin
                r_s1_v <= 1'b0;
            end
            if (w_xfer) begin
                r_mask     <= w_mask;
                r_any      <= w_any;
                r_all      <= w_all;
                r_mode_err <= w_mode_err;
                r_s2_v     <= 1'b1;
            end else if (i_out_ready) begin
                r_s2_v <= 1'b0;
            end
        end
    end

`ifdef SIMD_CMP_POPCOUNT_EN
    logic [CNT_W-1:0] w_count, r_count;

    always_comb begin
        w_count = '0;
        for (int i = 0; i < LANES_MAX; i++) w_count = w_count + CNT_W'(w_mask[i]);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)       r_count <= '0;
        else if (w_xfer) r_count <= w_count;
    end
    assign o_count = r_count;
`else
    assign o_count = '0;
`endif

    assign o_out_valid = r_s2_v;
    assign o_mask      = r_mask;
    assign o_any       = r_any;
    assign o_all       = r_all;
    assign o_mode_err  = r_mode_err;

endmodule

// File: tb/tb_simd_alu_cmp_mask_reducer.sv
// Directed bench for simd_alu_cmp_mask_reducer: reduction values, latency, back-pressure and reset.
module tb_simd_alu_cmp_mask_reducer;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready;
    logic [255:0] result;
    logic [1:0]   data_mode;
    logic         out_valid, out_ready;
    logic [31:0]  mask;
    logic         any_o, all_o, mode_err;
    logic [5:0]   count;
    int           n_assert = 0;
    int           n_fail   = 0;

    simd_alu_cmp_mask_reducer dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_result(result), .i_data_mode(data_mode), .o_out_valid(out_valid),
        .i_out_ready(out_ready), .o_mask(mask), .o_any(any_o), .o_all(all_o),
        .o_count(count), .o_mode_err(mode_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] ecnt(input int c);
`ifdef SIMD_CMP_POPCOUNT_EN
        return 6'(c);
`else
        return (c == 0) ? 6'd0 : 6'd0;
`endif
    endfunction

    // Non-LSB bits are 0xFE filler so only the selected lane LSBs are 1.
    function automatic logic [255:0] mk(input int mode, input logic [31:0] lanes);
        logic [255:0] r;
        r = {32{8'hFE}};
        for (int i = 0; i < (32 >> mode); i++)
            if (lanes[i]) r[i*(8<<mode)] = 1'b1;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic [31:0] em, input logic ea,
                           input logic el, input int c);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_mask"},  64'(mask),      64'(em));
        chk({tag, "_any"},   64'(any_o),     64'(ea));
        chk({tag, "_all"},   64'(all_o),     64'(el));
        chk({tag, "_count"}, 64'(count),     64'(ecnt(c)));
        chk({tag, "_merr"},  64'(mode_err),  64'd0);
    endtask

    task automatic single(input string tag, input logic [1:0] md, input logic [255:0] res,
                          input logic [31:0] em, input logic ea, input logic el, input int c);
        data_mode = md; result = res; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
        step();
        chk_out(tag, em, ea, el, c);
        step();
        chk({tag, "_drain"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; result = '0; data_mode = 2'd0; out_ready = 1'b1;
        step(); step();
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mask",      64'(mask),      64'd0);
        chk("rst_any",       64'(any_o),     64'd0);
        chk("rst_all",       64'(all_o),     64'd0);
        chk("rst_count",     64'(count),     64'd0);
        chk("rst_merr",      64'(mode_err),  64'd0);
        rst = 1'b0;
        #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Value checks, one item at a time.
        single("m0_sparse", 2'd0, mk(0, 32'h8000_0021), 32'h8000_0021, 1'b1, 1'b0, 3);
        single("m3_full",   2'd3, mk(3, 32'h0000_000F), 32'h0000_000F, 1'b1, 1'b1, 4);
        single("m1_full",   2'd1, {16{16'h0001}},       32'h0000_FFFF, 1'b1, 1'b1, 16);
        single("m2_zero",   2'd2, 256'h0,               32'h0000_0000, 1'b0, 1'b0, 0);
        single("m0_ones",   2'd0, {256{1'b1}},          32'hFFFF_FFFF, 1'b1, 1'b1, 32);
        single("m1_hibyte", 2'd1, {16{16'h0100}},       32'h0000_0000, 1'b0, 1'b0, 0);
        single("m2_part",   2'd2, mk(2, 32'h0000_007F), 32'h0000_007F, 1'b1, 1'b0, 7);

        // Back-to-back: item t carries lane t+1, expected on outputs after steps 1..4.
        out_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            in_valid  = (t < 4);
            data_mode = 2'd0;
            result    = mk(0, 32'd1 << (t + 1));
            step();
            if (t >= 1 && t <= 4) chk_out("b2b", 32'd1 << t, 1'b1, 1'b0, 1);
            else chk("b2b_idle", 64'(out_valid), 64'd0);
        end
        in_valid = 1'b0;

        // Stall: out_ready low for 5 cycles while A, B, C are offered.
        out_ready = 1'b0; in_valid = 1'b1; data_mode = 2'd0;
        result = mk(0, 32'd1 << 10);
        #1 chk("stall_rdyA", 64'(in_ready), 64'd1);
        step();
        result = mk(0, 32'd1 << 11);
        chk("stall_rdyB", 64'(in_ready), 64'd1);
        step();
        result = mk(0, 32'd1 << 12);
        for (int k = 0; k < 3; k++) begin
            chk("stall_rdyC", 64'(in_ready), 64'd0);
            chk_out("stall_hold", 32'd1 << 10, 1'b1, 1'b0, 1);
            step();
        end
        out_ready = 1'b1;
        #1 chk("release_rdy", 64'(in_ready), 64'd1);
        chk_out("drainA", 32'd1 << 10, 1'b1, 1'b0, 1);
        step();
        in_valid = 1'b0;
        chk_out("drainB", 32'd1 << 11, 1'b1, 1'b0, 1);
        step();
        chk_out("drainC", 32'd1 << 12, 1'b1, 1'b0, 1);
        step();
        chk("drain_empty", 64'(out_valid), 64'd0);

        // Reset with both stages occupied.
        out_ready = 1'b0; in_valid = 1'b1;
        result = mk(0, 32'd1 << 20);
        step();
        result = mk(0, 32'd1 << 21);
        step();
        in_valid = 1'b0;
        chk_out("full_before_rst", 32'd1 << 20, 1'b1, 1'b0, 1);
        rst = 1'b1;
        #1 chk("rst_mid_rdy", 64'(in_ready), 64'd0);
        step();
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_mask",  64'(mask),      64'd0);
        chk("rst_mid_any",   64'(any_o),     64'd0);
        chk("rst_mid_all",   64'(all_o),     64'd0);
        chk("rst_mid_count", 64'(count),     64'd0);
        rst = 1'b0; out_ready = 1'b1;
        #1 chk("rst_mid_rdy_after", 64'(in_ready), 64'd1);
        step();
        chk("rst_discard1", 64'(out_valid), 64'd0);
        step();
        chk("rst_discard2", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
